// File: rtl/seq_detect_ctrl_if.sv
// Word handshake between the parallel producer and the sequence detector
// front end. The producer drives data_i/valid_i; the controller answers
// with ready_o.
interface seq_detect_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);
endinterface : seq_detect_ctrl_if

// File: rtl/seq_detect_ctrl.sv
// Sequence detector front end: accepts parallel words over a valid/ready
// handshake, serializes them MSB-first into a PAT_W-bit history matcher,
// counts detections in a saturating counter and flags word completion.
// Optional build macro SEQ_OVERLAP_EN: when defined, history survives a
// match so overlapping occurrences are each detected; when undefined a
// match clears history and the next detection needs PAT_W fresh bits.
module seq_detect_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                PAT_W       = 4,
    parameter int                CNT_W       = 8,
    parameter logic [PAT_W-1:0]  PATTERN_RST = 4'b1011
) (
    input  logic                 clk,
    input  logic                 reset_i,
    seq_detect_ctrl_if.slave     word_if,
    input  logic [PAT_W-1:0]     cfg_pattern_i,
    input  logic                 cfg_we_i,
    input  logic                 clear_cnt_i,
    output logic                 bit_o,
    output logic                 bit_valid_o,
    output logic                 match_o,
    output logic [CNT_W-1:0]     match_cnt_o,
    output logic                 word_done_o,
    output logic                 busy_o
);

    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  word_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PAT_W-1:0]   hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [PAT_W-1:0]   pat_q;
    logic               match_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               ready;
    logic               accept;
    logic               cfg_ok;
    logic               shift_bit;
    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               match_det;

    // Handshake, configuration gating and the candidate history update.
    always_comb begin
        ready      = (state_q == IDLE) && !reset_i;
        accept     = ready && word_if.valid_i;
        cfg_ok     = (state_q == IDLE) && cfg_we_i;
        shift_bit  = word_q[idx_q];
        hist_shift = {hist_q[PAT_W-2:0], shift_bit};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        match_det  = (state_q == SHIFT) && (hist_shift == pat_q) &&
                     (fill_inc == FILL_FULL);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every flop is written with <= so all of them sample the
        // pre-edge values together; blocking here would create ordering races.
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: accept -> DATA_W shift cycles -> one report cycle.
    always_comb begin
        // NOTE: defaulting every comb output first keeps latches out when a
        // case branch forgets an assignment.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (idx_q == '0) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word latch and bit index.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            word_q <= word_if.data_i;
            idx_q  <= IDX_LAST;
        end else if (state_q == SHIFT && idx_q != '0) begin
            idx_q  <= idx_q - 1'b1;
        end
    end

    // Pattern register, history and fill count. A pattern write restarts
    // matching from scratch; history otherwise spans word boundaries.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            pat_q  <= PATTERN_RST;
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_ok) begin
            pat_q  <= cfg_pattern_i;
            hist_q <= '0;
            fill_q <= '0;
        end else if (state_q == SHIFT) begin
`ifdef SEQ_OVERLAP_EN
            hist_q <= hist_shift;
            fill_q <= fill_inc;
`else
            if (match_det) begin
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= hist_shift;
                fill_q <= fill_inc;
            end
`endif
        end
    end

    // Registered match pulse and saturating counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= match_det;
            if (clear_cnt_i)                 cnt_q <= '0;
            else if (match_q && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign word_if.ready_o = ready;
    assign bit_o           = (state_q == SHIFT) ? shift_bit : 1'b0;
    assign bit_valid_o     = (state_q == SHIFT);
    assign match_o         = match_q;
    assign match_cnt_o     = cnt_q;
    assign word_done_o     = (state_q == REPORT);
    assign busy_o          = (state_q != IDLE);

endmodule : seq_detect_ctrl

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with hand-computed match timing.
// The DUT is built with CNT_W=2 so counter saturation is reachable.
module tb_seq_detect_ctrl;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 2;

    // Match masks: bit k set means match_o high k negedges after accept
    // (k=0..7 are the shift cycles, k=8 is the report cycle).
`ifdef SEQ_OVERLAP_EN
    localparam logic [8:0] M_AA_FRESH = 9'h150;  // 1010 after a pattern write
    localparam logic [8:0] M_AA_WARM  = 9'h154;  // 1010 with history already 1010
    localparam int         CNT_AA     = 3;
    localparam int         CNT_AA_2   = 3;
`else
    localparam logic [8:0] M_AA_FRESH = 9'h110;
    localparam logic [8:0] M_AA_WARM  = 9'h110;
    localparam int         CNT_AA     = 2;
    localparam int         CNT_AA_2   = 2;
`endif

    logic             clk = 1'b0;
    logic             reset_i;
    logic [PAT_W-1:0] cfg_pattern_i;
    logic             cfg_we_i;
    logic             clear_cnt_i;
    logic             bit_o, bit_valid_o, match_o, word_done_o, busy_o;
    logic [CNT_W-1:0] match_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    seq_detect_ctrl_if #(.DATA_W(DATA_W)) word_if ();

    seq_detect_ctrl #(
        .DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .PATTERN_RST(4'b1011)
    ) dut (
        .clk(clk), .reset_i(reset_i), .word_if(word_if),
        .cfg_pattern_i(cfg_pattern_i), .cfg_we_i(cfg_we_i),
        .clear_cnt_i(clear_cnt_i), .bit_o(bit_o), .bit_valid_o(bit_valid_o),
        .match_o(match_o), .match_cnt_o(match_cnt_o),
        .word_done_o(word_done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle pulse helpers, entered and left at a negedge in IDLE.
    task automatic clear_cnt_idle();
        clear_cnt_i = 1'b1;
        @(negedge clk);
        clear_cnt_i = 1'b0;
    endtask

    task automatic cfg_idle(input logic [PAT_W-1:0] pat);
        cfg_we_i = 1'b1; cfg_pattern_i = pat;
        @(negedge clk);
        cfg_we_i = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!word_if.ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(word_if.ready_o), 1);
    endtask

    // Sends one word and checks the whole DATA_W+2 cycle window.
    // cfg_acc: pattern write in the accept cycle; clr_at/cfg_at: window
    // cycle at which clear_cnt_i / cfg_we_i is driven (-1 for none).
    task automatic send_word(input string tag, input logic [7:0] data,
                             input logic [8:0] exp_match, input logic cfg_acc,
                             input logic [PAT_W-1:0] cfg_val,
                             input int clr_at, input int cfg_at);
        logic [8:0] m_mask, d_mask, v_mask, b_mask, r_mask;
        logic [7:0] bits;
        m_mask = '0; d_mask = '0; v_mask = '0; b_mask = '0; r_mask = '0; bits = '0;
        wait_ready(tag);
        word_if.data_i  = data;
        word_if.valid_i = 1'b1;
        if (cfg_acc) begin
            cfg_we_i = 1'b1; cfg_pattern_i = cfg_val;
        end
        @(posedge clk);
        #1;
        word_if.valid_i = 1'b0;
        word_if.data_i  = '0;
        cfg_we_i        = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            m_mask[k] = match_o;
            d_mask[k] = word_done_o;
            v_mask[k] = bit_valid_o;
            b_mask[k] = busy_o;
            r_mask[k] = word_if.ready_o;
            if (k < 8) bits[7-k] = bit_o;
            clear_cnt_i = (k == clr_at);
            if (k == cfg_at) begin
                cfg_we_i = 1'b1; cfg_pattern_i = 4'b1111;
            end else begin
                cfg_we_i = 1'b0;
            end
        end
        @(negedge clk);
        clear_cnt_i = 1'b0;
        cfg_we_i    = 1'b0;
        check({tag, "_match_mask"}, 32'(m_mask), 32'(exp_match));
        check({tag, "_done_mask"},  32'(d_mask), 32'h100);
        check({tag, "_bitv_mask"},  32'(v_mask), 32'h0FF);
        check({tag, "_busy_mask"},  32'(b_mask), 32'h1FF);
        check({tag, "_ready_mask"}, 32'(r_mask), 32'h000);
        check({tag, "_bits"},       32'(bits),   32'(data));
        check({tag, "_ready_after"}, 32'(word_if.ready_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_done, seen_match;
        reset_i = 1'b1; word_if.data_i = '0; word_if.valid_i = 1'b0;
        cfg_pattern_i = '0; cfg_we_i = 1'b0; clear_cnt_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(word_if.ready_o), 0);
        check("rst_busy",   32'(busy_o), 0);
        check("rst_bitv",   32'(bit_valid_o), 0);
        check("rst_bit",    32'(bit_o), 0);
        check("rst_match",  32'(match_o), 0);
        check("rst_cnt",    32'(match_cnt_o), 0);
        check("rst_done",   32'(word_done_o), 0);
        reset_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(word_if.ready_o), 1);

        // Reset pattern 1011 found on the 4th bit.
        send_word("w1", 8'b1011_0000, 9'h010, 1'b0, '0, -1, -1);
        check("w1_cnt", 32'(match_cnt_o), 1);

        // Two matches, the second pulsing during REPORT.
        clear_cnt_idle();
        check("clr_idle_cnt", 32'(match_cnt_o), 0);
        send_word("w2", 8'b1011_1011, 9'h110, 1'b0, '0, -1, -1);
        check("w2_cnt", 32'(match_cnt_o), 2);

        // Cross-word detection after a history-clearing pattern write.
        cfg_idle(4'b1011);
        send_word("w3a", 8'b0000_0101, 9'h000, 1'b0, '0, -1, -1);
        send_word("w3b", 8'b1000_0000, 9'h002, 1'b0, '0, -1, -1);
        check("w3_cnt", 32'(match_cnt_o), 3);

        // Pattern 1010 written in the accept cycle applies to that word.
        clear_cnt_idle();
        send_word("w4", 8'b1010_1010, M_AA_FRESH, 1'b1, 4'b1010, -1, -1);
        check("w4_cnt", 32'(match_cnt_o), CNT_AA);

        // Counter saturates at 3.
        send_word("w5a", 8'b1010_1010, M_AA_WARM, 1'b0, '0, -1, -1);
        send_word("w5b", 8'b1010_1010, M_AA_WARM, 1'b0, '0, -1, -1);
        check("w5_sat_cnt", 32'(match_cnt_o), 3);

        // Clear coincident with the REPORT-cycle match pulse wins.
        send_word("w6", 8'b1010_1010, M_AA_WARM, 1'b0, '0, 8, -1);
        check("w6_clr_cnt", 32'(match_cnt_o), 0);

        // Pattern write during SHIFT is ignored.
        send_word("w7", 8'b1010_1010, M_AA_WARM, 1'b0, '0, -1, 2);
        check("w7_cnt", 32'(match_cnt_o), CNT_AA_2);

        // Reset mid-word, just as a match is about to be registered.
        wait_ready("w8");
        word_if.data_i = 8'b1010_0000; word_if.valid_i = 1'b1;
        @(posedge clk);
        #1;
        word_if.valid_i = 1'b0; word_if.data_i = '0;
        repeat (4) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("midrst_busy",  32'(busy_o), 0);
        check("midrst_bitv",  32'(bit_valid_o), 0);
        check("midrst_bit",   32'(bit_o), 0);
        check("midrst_match", 32'(match_o), 0);
        check("midrst_cnt",   32'(match_cnt_o), 0);
        check("midrst_done",  32'(word_done_o), 0);
        check("midrst_ready", 32'(word_if.ready_o), 0);
        reset_i = 1'b0;
        seen_done = 1'b0; seen_match = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_done  |= word_done_o;
            seen_match |= match_o;
        end
        check("midrst_no_done",  32'(seen_done), 0);
        check("midrst_no_match", 32'(seen_match), 0);
        check("midrst_ready_after", 32'(word_if.ready_o), 1);

        // Reset restored the default pattern.
        send_word("w9", 8'b1011_0000, 9'h010, 1'b0, '0, -1, -1);
        check("w9_cnt", 32'(match_cnt_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_seq_detect_ctrl

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Front-end controller for the serial sequence detector path. Accepts parallel words over a valid/ready handshake and serializes them MSB-first into an internal PAT_W-bit history matcher. Holds a runtime-programmable pattern, counts detections in a saturating counter, and flags completion of each word. Sits between the word-oriented producer and the bit-serial detection logic, and owns its sequencing and configuration.

Parameters:
DATA_W, 8, width of each input word (number of serial bits per word)
PAT_W, 4, pattern/history length in bits
CNT_W, 8, width of the match counter
PATTERN_RST, 4'b1011, pattern register value after reset (width PAT_W)

Ports:
clk  in  1  system clock; all logic on posedge
reset_i  in  1  synchronous, active-high reset
data_i  in  DATA_W  parallel word to serialize
valid_i  in  1  data_i valid
ready_o  out  1  controller can accept a word
cfg_pattern_i  in  PAT_W  new pattern value
cfg_we_i  in  1  pattern write strobe
clear_cnt_i  in  1  clear match counter
bit_o  out  1  current serialized bit
bit_valid_o  out  1  bit_o is a live stream bit
match_o  out  1  one-cycle detection pulse
match_cnt_o  out  CNT_W  saturating detection count
word_done_o  out  1  one-cycle pulse, word fully shifted
busy_o  out  1  word in progress

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset_i); it is sampled on posedge clk only.
- Reset: state IDLE; bit_o=0, bit_valid_o=0, match_o=0, match_cnt_o=0, word_done_o=0, busy_o=0. History and fill count are cleared, and the pattern register is set to PATTERN_RST. ready_o=0 while reset_i=1.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE: ready_o=1 and busy_o=0. On valid_i&&ready_o, latch data_i, clear the bit index to DATA_W-1, and enter SHIFT.
- SHIFT: ready_o=0, busy_o=1, bit_valid_o=1, bit_o=word[idx].
  - Each cycle: history <= {history[PAT_W-2:0], bit_o}; fill count increments, saturating at PAT_W; idx decrements.
  - After the idx=0 cycle, enter REPORT. The word occupies exactly DATA_W SHIFT cycles.
- REPORT: one cycle. word_done_o=1, busy_o=1, ready_o=0. Next state is IDLE.
- Per-word cost: 1 accept cycle + DATA_W + 1 = DATA_W+2 cycles.
- Match detection:
  - Condition: the updated history equals the pattern AND the updated fill count equals PAT_W.
  - match_o is registered: it is high in the cycle after the SHIFT cycle that completed the pattern. A match on the last bit therefore pulses during REPORT.
- History persists across words, so patterns may span word boundaries. Only reset, a pattern write, or a match in non-overlap mode clears it.
- Counter: match_cnt_o increments on each match and saturates at 2^CNT_W-1 (no wrap). clear_cnt_i zeroes it on the next edge. If clear and match occur in the same cycle, clear wins and the result is 0.
- cfg_we_i:
  - Honoured only in IDLE. It loads the pattern and clears history and fill count.
  - Ignored in SHIFT and REPORT (no latching, no side effects).
  - If cfg_we_i and an accepted valid_i occur in the same IDLE cycle, both take effect; the new pattern applies to the accepted word.
- valid_i is ignored outside IDLE. data_i must be held only during the accept cycle.
- Reset mid-word: the word is abandoned, no word_done_o pulses, and a pending match_o is dropped.

Optional Feature:
SEQ_OVERLAP_EN: when defined, history and fill count are retained after a match, so overlapping occurrences are each detected. When undefined (default), history and fill count are cleared on a match, so the next detection needs PAT_W fresh bits (non-overlapping).

Test Plan:
- Reset, then idle → ready_o=1 one cycle after reset_i falls, match_cnt_o=0, and the pattern equals 4'b1011 (verified by sending word 8'b1011_0000 → one match_o, in the cycle after the 4th bit).
- Default pattern, word 8'b1011_1011 → match_o after bits 4 and 8 (second pulse during REPORT), match_cnt_o=2, word_done_o 9 cycles after accept, ready_o high on the following cycle.
- Write pattern 4'b1010 in IDLE, word 8'b1010_1010 → 2 matches without SEQ_OVERLAP_EN, 3 matches with it.
- Default pattern, words 8'b0000_0101 then 8'b1000_0000 → exactly 1 match_o, on the first bit of the second word (cross-word detection).
- CNT_W=2, four matching words → match_cnt_o saturates at 3. Assert clear_cnt_i in the same cycle as a match_o → match_cnt_o=0.
- cfg_we_i during SHIFT → pattern unchanged. reset_i asserted mid-SHIFT → outputs return to reset values the next cycle, and no word_done_o pulses.
